// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: owns the fetch PC, captures ROM words with their PC into a
// first-word-fall-through buffer drained by decode, and handles redirect, halt and fetch faults.
module fetch_controller #(
  parameter int unsigned MEM_SIZE = 1024,
  parameter int unsigned DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'd0
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        halt,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [63:0] out_pc,
  output logic        fault
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
  localparam logic [63:0] LAST_PC = 64'(MEM_SIZE - 4);

  logic [63:0]      fetch_pc;
  logic [PTR_W-1:0] rd_ptr, wr_ptr, rd_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic [63:0]      pc_mem    [DEPTH];
  logic [31:0]      instr_mem [DEPTH];

  logic bad_pc, space, pop, fetch_ok, fetch, fault_set, head_from_push;

  assign imem_addr = fetch_pc;

  // Push/pop/fault decode for this cycle
  always_comb begin
    bad_pc         = 1'b0;
    space          = 1'b0;
    pop            = 1'b0;
    fetch_ok       = 1'b0;
    fetch          = 1'b0;
    fault_set      = 1'b0;
    rd_nxt         = rd_ptr;
    count_nxt      = count;
    head_from_push = 1'b0;

    bad_pc    = (fetch_pc[1:0] != 2'b00) || (fetch_pc > LAST_PC);
    pop       = out_valid & out_ready & ~redirect_valid;
    space     = (count < CNT_W'(DEPTH)) | pop;
    fetch_ok  = ~redirect_valid & ~halt & ~fault & space;
    fetch     = fetch_ok & ~bad_pc;
    fault_set = fetch_ok & bad_pc;

    if (pop) rd_nxt = rd_ptr + PTR_W'(1);
    if (fetch && !pop)      count_nxt = count + CNT_W'(1);
    else if (!fetch && pop) count_nxt = count - CNT_W'(1);

    // The next head is the word being written this edge when the buffer was empty at that slot
    head_from_push = fetch && (rd_nxt == wr_ptr);
  end

  // Buffer storage; contents are only meaningful while counted
  always_ff @(posedge clk) begin
    if (fetch) begin
      pc_mem[wr_ptr]    <= fetch_pc;
      instr_mem[wr_ptr] <= imem_instr;
    end
  end

  // Control state and registered head outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc  <= RESET_PC;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      fault     <= 1'b0;
      out_valid <= 1'b0;
      out_pc    <= '0;
      out_instr <= '0;
    end else if (redirect_valid) begin
      fetch_pc  <= redirect_pc;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      fault     <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (fetch) begin
        wr_ptr   <= wr_ptr + PTR_W'(1);
        fetch_pc <= fetch_pc + 64'd4;
      end
      if (fault_set) fault <= 1'b1;
      rd_ptr    <= rd_nxt;
      count     <= count_nxt;
      out_valid <= (count_nxt != '0);
      if (count_nxt != '0) begin
        if (head_from_push) begin
          out_pc    <= fetch_pc;
          out_instr <= imem_instr;
        end else begin
          out_pc    <= pc_mem[rd_nxt];
          out_instr <= instr_mem[rd_nxt];
        end
      end
    end
  end

endmodule
